// File: rtl/mealy_match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_match_pkg
//  Description : Shared types and default sizing for the 10110 match monitor.
//                The FIFO state enum is used by match_pos_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package mealy_match_pkg;

    // Default sizing for the monitor top and the position FIFO
    localparam int c_DEF_CNT_W = 8;
    localparam int c_DEF_POS_W = 16;
    localparam int c_DEF_DEPTH = 4;

    // Position FIFO occupancy state
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

endpackage : mealy_match_pkg
`default_nettype wire

// File: rtl/match_pos_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : match_pos_fifo
//  Description : First-word-fall-through FIFO holding the bit positions of
//                detected matches. Occupancy is tracked by a three-state FSM
//                (EMPTY / PARTIAL / FULL); a push while full with no pop in
//                the same cycle is discarded and flagged in a sticky bit.
//                clr has priority over every same-cycle push or pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_pos_fifo
    import mealy_match_pkg::*;
#(
    parameter int POS_W = c_DEF_POS_W,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_req,
    input  logic [POS_W-1:0] push_data,
    input  logic             pop_ready,
    output logic             pos_valid,
    output logic [POS_W-1:0] pos_data,
    output logic             fifo_full,
    output logic             dropped
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [POS_W-1:0]   r_mem [DEPTH];
    fifo_state_t        r_state;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_dropped;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_PTR_W-1:0] w_wr_nxt;
    logic [c_PTR_W-1:0] w_rd_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when the consumer is draining it.
    assign w_pop    = (r_state != EMPTY) && pop_ready && !clr;
    assign w_push   = push_req && !clr && ((r_state != FULL) || w_pop);
    assign w_drop   = push_req && !clr && (r_state == FULL) && !w_pop;
    assign w_wr_nxt = r_wr_ptr + c_PTR_ONE;
    assign w_rd_nxt = r_rd_ptr + c_PTR_ONE;

    // Storage write; contents need no reset because reads are gated by state
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Occupancy FSM, pointers and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state   <= EMPTY;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_dropped <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (w_push && !w_pop && (w_wr_nxt == r_rd_ptr)) begin
                        r_state <= FULL;
                    end else if (w_pop && !w_push && (w_rd_nxt == r_wr_ptr)) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop && !w_push) begin
                        r_state <= PARTIAL;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign pos_valid = (r_state != EMPTY);
    assign fifo_full = (r_state == FULL);
    assign pos_data  = pos_valid ? r_mem[r_rd_ptr] : '0;
    assign dropped   = r_dropped;

endmodule : match_pos_fifo
`default_nettype wire

// File: rtl/mealy_match_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_match_monitor
//  Description : Counts match pulses from a 10110 serial detector and, when
//                MATCH_POS_FIFO_EN is defined, records the bit position of
//                each match in a small FWFT FIFO. Without the macro the
//                position path is absent and its outputs are tied to zero.
//  Config      : `MATCH_POS_FIFO_EN - enables bit_pos counter and FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_match_monitor
    import mealy_match_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int POS_W = c_DEF_POS_W,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             det_in,
    input  logic             clr,
    output logic [CNT_W-1:0] match_cnt,
    output logic             overflow,
    output logic             pos_valid,
    output logic [POS_W-1:0] pos_data,
    input  logic             pos_ready,
    output logic             fifo_full,
    output logic             dropped
);

    logic [CNT_W-1:0] r_match_cnt;
    logic             r_overflow;

    // Saturating match counter; overflow latches on a match seen at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_match_cnt <= '0;
            r_overflow  <= 1'b0;
        end else if (det_in) begin
            if (r_match_cnt == {CNT_W{1'b1}}) begin
                r_overflow <= 1'b1;
            end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
        end
    end

    assign match_cnt = r_match_cnt;
    assign overflow  = r_overflow;

`ifdef MATCH_POS_FIFO_EN
    logic [POS_W-1:0] r_bit_pos;

    // Running count of serial bits; det_in lags the final pattern bit by one
    // cycle, so the current value is the 1-based index of that bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_bit_pos <= '0;
        end else if (bit_valid) begin
            r_bit_pos <= r_bit_pos + 1'b1;
        end
    end

    match_pos_fifo #(
        .POS_W (POS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push_req  (det_in),
        .push_data (r_bit_pos),
        .pop_ready (pos_ready),
        .pos_valid (pos_valid),
        .pos_data  (pos_data),
        .fifo_full (fifo_full),
        .dropped   (dropped)
    );
`else
    // Position path absent: inputs kept on the port list but not consumed
    logic w_unused_ok;
    assign w_unused_ok = bit_valid ^ pos_ready ^ (DEPTH == 0);

    assign pos_valid = 1'b0;
    assign pos_data  = '0;
    assign fifo_full = 1'b0;
    assign dropped   = 1'b0;
`endif

endmodule : mealy_match_monitor
`default_nettype wire

// File: tb/tb_mealy_match_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mealy_match_monitor
//  Description : Self-checking bench for mealy_match_monitor. A queue-based
//                reference model predicts every output each cycle; directed
//                sequences cover the documented scenarios, then randomized
//                traffic exercises clear/reset/full/drop interleavings.
//  Config      : `MATCH_POS_FIFO_EN - selects FIFO expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_match_monitor;

    localparam int CNT_W = 8;
    localparam int POS_W = 16;
    localparam int DEPTH = 4;
`ifdef MATCH_POS_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_valid = 1'b0;
    logic             det_in = 1'b0;
    logic             clr = 1'b0;
    logic             pos_ready = 1'b0;
    logic [CNT_W-1:0] match_cnt;
    logic             overflow;
    logic             pos_valid;
    logic [POS_W-1:0] pos_data;
    logic             fifo_full;
    logic             dropped;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_cnt  = 0;
    bit m_ovf  = 1'b0;
    int m_pos  = 0;
    bit m_drop = 1'b0;
    int m_q[$];

    mealy_match_monitor #(
        .CNT_W (CNT_W),
        .POS_W (POS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .det_in    (det_in),
        .clr       (clr),
        .match_cnt (match_cnt),
        .overflow  (overflow),
        .pos_valid (pos_valid),
        .pos_data  (pos_data),
        .pos_ready (pos_ready),
        .fifo_full (fifo_full),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic drive_cycle(input logic bv, input logic det, input logic rdy,
                               input logic cl, input logic rs);
        bit popped;
        bit_valid = bv;
        det_in    = det;
        pos_ready = rdy;
        clr       = cl;
        rst       = rs;
        @(posedge clk);
        if (rs || cl) begin
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_pos  = 0;
            m_drop = 1'b0;
            m_q.delete();
        end else begin
            popped = (m_q.size() > 0) && rdy;
            if (det) begin
                if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1'b1;
                else m_cnt++;
            end
            if (FIFO_EN) begin
                if (popped) void'(m_q.pop_front());
                if (det) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_pos);
                    else m_drop = 1'b1;
                end
                if (bv) m_pos = (m_pos + 1) % (1 << POS_W);
            end
        end
        #1;
        check("match_cnt", 32'(match_cnt), 32'(m_cnt));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("pos_valid", 32'(pos_valid), 32'(m_q.size() > 0));
        check("pos_data",  32'(pos_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check("dropped",   32'(dropped),   32'(m_drop));
    endtask

    // Feed a bit stream MSB-first through a behavioural 10110 detector whose
    // registered output arrives on det_in one cycle after the final bit.
    task automatic send_bits(input logic [31:0] bits, input int n, input logic rdy);
        logic [31:0] b;
        logic [4:0]  hist;
        logic        det_p;
        b     = bits;
        hist  = 5'b0;
        det_p = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, det_p, rdy, 1'b0, 1'b0);
            hist  = {hist[3:0], b[n-1-i]};
            det_p = (hist == 5'b10110);
        end
        drive_cycle(1'b0, det_p, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_cnt",   32'(match_cnt), 32'd0);
        check("rst_valid", 32'(pos_valid), 32'd0);
        check("rst_data",  32'(pos_data),  32'd0);

        // Single match: 1,0,1,1,0
        send_bits(32'b10110, 5, 1'b0);
        check("single_cnt", 32'(match_cnt), 32'd1);
`ifdef MATCH_POS_FIFO_EN
        check("single_valid", 32'(pos_valid), 32'd1);
        check("single_pos",   32'(pos_data),  32'd5);
`endif

        // Overlapping matches: 1,0,1,1,0,1,1,0 -> positions 5 and 8
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(32'b10110110, 8, 1'b0);
        check("overlap_cnt", 32'(match_cnt), 32'd2);
`ifdef MATCH_POS_FIFO_EN
        check("overlap_pos0", 32'(pos_data), 32'd5);
`endif
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef MATCH_POS_FIFO_EN
        check("overlap_pos1", 32'(pos_data), 32'd8);
`endif
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("overlap_empty", 32'(pos_valid), 32'd0);

        // Five matches with no consumer: fill, drop the fifth
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fill_cnt", 32'(match_cnt), 32'd5);
`ifdef MATCH_POS_FIFO_EN
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_drop", 32'(dropped),   32'd1);
`endif
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Counter saturation at 255 with overflow on the 256th pulse
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_ovf_lo", 32'(overflow), 32'd0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_cnt", 32'(match_cnt), 32'd255);
        check("sat_ovf", 32'(overflow),  32'd1);

        // clr wins over a same-cycle match; next bit is position 1
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_cnt",   32'(match_cnt), 32'd0);
        check("clr_valid", 32'(pos_valid), 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MATCH_POS_FIFO_EN
        check("clr_pos1", 32'(pos_data), 32'd1);
`endif

        // Full FIFO with simultaneous pop and push: no drop
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef MATCH_POS_FIFO_EN
        check("pp_full", 32'(fifo_full), 32'd1);
        check("pp_drop", 32'(dropped),   32'd0);
        check("pp_head", 32'(pos_data),  32'd1);
`endif

        // bit_pos wrap from 2^POS_W-1 to 0
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < (1 << POS_W) - 1; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive_cycle(1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 9) < 4),
                        1'($urandom_range(0, 9) < 4),
                        1'($urandom_range(0, 99) < 2),
                        1'($urandom_range(0, 199) < 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mealy_match_monitor
`default_nettype wire
